seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_pkg.sv | 48 ++++
 rtl/seg_scan_driver_if.sv | 27 ++
 rtl/seg_decoder.sv | 17 +
 rtl/seg_scan_driver.sv | 146 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared segment constants and code decode for the multiplexed seven-segment scanner.
// Segment byte layout: bit 7 = dp, bits 6..0 = a..g.
package seg_pkg;

    localparam int unsigned DP_BIT = 7;

    localparam logic [3:0] DASH = 4'd10;

    localparam logic [7:0] SEG_0     = 8'h7E;
    localparam logic [7:0] SEG_1     = 8'h30;
    localparam logic [7:0] SEG_2     = 8'h6D;
    localparam logic [7:0] SEG_3     = 8'h79;
    localparam logic [7:0] SEG_4     = 8'h33;
    localparam logic [7:0] SEG_5     = 8'h5B;
    localparam logic [7:0] SEG_6     = 8'h5F;
    localparam logic [7:0] SEG_7     = 8'h70;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h7B;
    localparam logic [7:0] SEG_DASH  = 8'h01;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // One digit's worth of state latched at the start of a scan slot.
    typedef struct packed {
        logic [3:0] code;
        logic       dp;
        logic       blink;
    } digit_cap_t;

    function automatic logic [7:0] seg_pattern(input logic [3:0] code);
        logic [7:0] pat;
        case (code)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            DASH:    pat = SEG_DASH;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-side bundle: digit/mask/brightness controls in, position select and segment drive out.
// slave is the scanner's view, master is the controller's view.
interface seg_scan_driver_if #(
    parameter int N_POS = 4
);
    logic [8*N_POS-1:0] digits;
    logic [2*N_POS-1:0] dp_mask;
    logic [2*N_POS-1:0] blink_mask;
    logic [N_POS-1:0]   lzb;
    logic [2:0]         bright;
    logic               en;

    logic [N_POS-1:0]   wei;
    logic [7:0]         duan;
    logic [7:0]         duan1;
    logic               frame_tick;

    modport master (
        output digits, dp_mask, blink_mask, lzb, bright, en,
        input  wei, duan, duan1, frame_tick
    );

    modport slave (
        input  digits, dp_mask, blink_mask, lzb, bright, en,
        output wei, duan, duan1, frame_tick
    );
endinterface

// File: rtl/seg_decoder.sv
// Combinational 4-bit code to segment byte, with dp insert and forced blank of a..g.
// Zero latency, no backpressure.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg         = blank ? SEG_BLANK : seg_pattern(code);
        seg[DP_BIT] = dp;
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed dual-bank seven-segment scanner with dead time, PWM dimming, blink and LZB.
// All outputs registered (one cycle after state); free-running, no backpressure.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int N_POS        = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int DEAD         = 64,
    parameter int BLINK_FRAMES = 125
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_driver_if.slave  bus
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int POS_W  = (N_POS > 1) ? $clog2(N_POS) : 1;
    localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [FRM_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              blink_ph_q, blink_ph_d;

    digit_cap_t        cap_lo_q, cap_lo_d;
    digit_cap_t        cap_hi_q, cap_hi_d;
    logic              cap_lzb_q, cap_lzb_d;

    logic [N_POS-1:0]  wei_q, wei_d;
    logic [7:0]        duan_q, duan_d;
    logic [7:0]        duan1_q, duan1_d;
    logic              frame_tick_q, frame_tick_d;

    logic              slot_wrap;
    logic              frame_end;
    logic              wei_on;
    logic              lo_blink_off;
    logic              hi_blink_off;
    logic              hi_lzb_off;
    logic [7:0]        lo_seg;
    logic [7:0]        hi_seg;

    always_comb begin
        slot_wrap   = (slot_cnt_q == SLOT_W'(SCAN_DIV - 1));
        frame_end   = slot_wrap && (pos_q == POS_W'(N_POS - 1));

        slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;

        pos_d = pos_q;
        if (slot_wrap) begin
            pos_d = (pos_q == POS_W'(N_POS - 1)) ? '0 : pos_q + 1'b1;
        end

        frame_cnt_d = frame_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (frame_end) begin
            if (frame_cnt_q == FRM_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
        frame_tick_d = frame_end;
    end

    // Latch this position's codes and flags once per slot so mid-slot input edits never tear a digit.
    always_comb begin
        cap_lo_d  = cap_lo_q;
        cap_hi_d  = cap_hi_q;
        cap_lzb_d = cap_lzb_q;
        if (slot_cnt_q == '0) begin
            cap_lo_d.code  = bus.digits[{pos_q, 3'b000} +: 4];
            cap_hi_d.code  = bus.digits[{pos_q, 3'b100} +: 4];
            cap_lo_d.dp    = bus.dp_mask[{pos_q, 1'b0}];
            cap_hi_d.dp    = bus.dp_mask[{pos_q, 1'b1}];
            cap_lo_d.blink = bus.blink_mask[{pos_q, 1'b0}];
            cap_hi_d.blink = bus.blink_mask[{pos_q, 1'b1}];
            cap_lzb_d      = bus.lzb[pos_q];
        end
    end

    // Dead time at slot start, then a PWM window on the low counter bits sets brightness.
    always_comb begin
        wei_on = bus.en
              && (slot_cnt_q >= SLOT_W'(DEAD))
              && (slot_cnt_q[2:0] <= bus.bright);
        wei_d  = wei_on ? (N_POS'(1) << pos_q) : '0;

        lo_blink_off = cap_lo_q.blink & blink_ph_q;
        hi_blink_off = cap_hi_q.blink & blink_ph_q;
        hi_lzb_off   = cap_lzb_q && (cap_hi_q.code == 4'd0);

        duan_d  = wei_on ? lo_seg : SEG_BLANK;
        duan1_d = wei_on ? hi_seg : SEG_BLANK;
    end

    seg_decoder u_dec_lo (
        .code  (cap_lo_q.code),
        .dp    (cap_lo_q.dp & ~lo_blink_off),
        .blank (lo_blink_off),
        .seg   (lo_seg)
    );

    // Blink must also kill dp; LZB only blanks a..g and leaves dp to the mask.
    seg_decoder u_dec_hi (
        .code  (cap_hi_q.code),
        .dp    (cap_hi_q.dp & ~hi_blink_off),
        .blank (hi_blink_off | hi_lzb_off),
        .seg   (hi_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q   <= '0;
            pos_q        <= '0;
            frame_cnt_q  <= '0;
            blink_ph_q   <= 1'b0;
            cap_lo_q     <= '0;
            cap_hi_q     <= '0;
            cap_lzb_q    <= 1'b0;
            wei_q        <= '0;
            duan_q       <= '0;
            duan1_q      <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            pos_q        <= pos_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_ph_q   <= blink_ph_d;
            cap_lo_q     <= cap_lo_d;
            cap_hi_q     <= cap_hi_d;
            cap_lzb_q    <= cap_lzb_d;
            wei_q        <= wei_d;
            duan_q       <= duan_d;
            duan1_q      <= duan1_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.wei        = wei_q;
    assign bus.duan       = duan_q;
    assign bus.duan1      = duan1_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random traffic against a cycle-count reference model.
module tb_seg_scan_driver;

    localparam int NP = 4;
    localparam int SD = 16;
    localparam int DT = 4;
    localparam int BF = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seg_scan_driver_if #(.N_POS(NP)) bus ();

    seg_scan_driver #(
        .N_POS        (NP),
        .SCAN_DIV     (SD),
        .DEAD         (DT),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference segment bytes, dp a b c d e f g.
    logic [7:0] seg_tab [16] = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70,
                                 8'h7F, 8'h7B, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    // Model state: cycles since reset plus what the display latched at slot start.
    int       m_cyc = 0;
    logic [3:0] m_code [2];
    logic       m_dp   [2];
    logic       m_blk  [2];
    logic       m_lzb;

    int wei_hi = 0;
    int ticks  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (model cycle %0d)", tag, got, exp, m_cyc);
        end
    endtask

    function automatic logic [7:0] ref_seg(input logic [3:0] code, input logic dp, input logic blk,
                                           input logic lzb_on, input bit lit, input bit blink_ph);
        logic [7:0] s;
        if (!lit)                      s = 8'h00;
        else if (blk && blink_ph)      s = 8'h00;
        else begin
            s = (lzb_on && code == 4'd0) ? 8'h00 : seg_tab[code];
            if (dp) s = s | 8'h80;
        end
        return s;
    endfunction

    task automatic step();
        int slot, pos, frm;
        bit blink_ph, lit, was_rst;
        logic [NP-1:0] e_wei;
        logic [7:0] e_lo, e_hi;
        logic e_tick;
        logic [3:0] c_lo, c_hi;
        logic d_lo, d_hi, b_lo, b_hi, z;

        slot     = m_cyc % SD;
        pos      = (m_cyc / SD) % NP;
        frm      = m_cyc / (SD * NP);
        blink_ph = ((frm / BF) % 2) == 1;
        lit      = bus.en && slot >= DT && (slot % 8) <= int'(bus.bright);
        was_rst  = rst;

        c_lo = bus.digits[8*pos +: 4];
        c_hi = bus.digits[8*pos+4 +: 4];
        d_lo = bus.dp_mask[2*pos];
        d_hi = bus.dp_mask[2*pos+1];
        b_lo = bus.blink_mask[2*pos];
        b_hi = bus.blink_mask[2*pos+1];
        z    = bus.lzb[pos];

        if (was_rst) begin
            e_wei = '0; e_lo = 8'h00; e_hi = 8'h00; e_tick = 1'b0;
        end else begin
            e_wei  = lit ? NP'(1 << pos) : '0;
            e_lo   = ref_seg(m_code[0], m_dp[0], m_blk[0], 1'b0,  lit, blink_ph);
            e_hi   = ref_seg(m_code[1], m_dp[1], m_blk[1], m_lzb, lit, blink_ph);
            e_tick = (slot == SD - 1) && (pos == NP - 1);
        end

        @(posedge clk);
        #1;
        chk("wei",        32'(bus.wei),        32'(e_wei));
        chk("duan",       32'(bus.duan),       32'(e_lo));
        chk("duan1",      32'(bus.duan1),      32'(e_hi));
        chk("frame_tick", 32'(bus.frame_tick), 32'(e_tick));
        if (bus.wei != '0) wei_hi++;
        if (bus.frame_tick) ticks++;

        if (was_rst) begin
            m_cyc = 0;
            for (int i = 0; i < 2; i++) begin
                m_code[i] = '0; m_dp[i] = 1'b0; m_blk[i] = 1'b0;
            end
            m_lzb = 1'b0;
        end else begin
            if (slot == 0) begin
                m_code[0] = c_lo; m_code[1] = c_hi;
                m_dp[0]   = d_lo; m_dp[1]   = d_hi;
                m_blk[0]  = b_lo; m_blk[1]  = b_hi;
                m_lzb     = z;
            end
            m_cyc++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.digits     = '0;
        bus.dp_mask    = '0;
        bus.blink_mask = '0;
        bus.lzb        = '0;
        bus.bright     = 3'd0;
        bus.en         = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_code[i] = '0; m_dp[i] = 1'b0; m_blk[i] = 1'b0;
        end
        m_lzb = 1'b0;

        rst = 1'b1;
        run(3);
        rst = 1'b0;

        // Upper/lower per position: 7/8, 5/6, 3/4, 1/2.
        bus.digits = 32'h1234_5678;
        bus.en     = 1'b1;
        bus.bright = 3'd7;
        wei_hi = 0; ticks = 0;
        run(64);
        chk("lit_cycles_b7", 32'(wei_hi), 32'd48);
        chk("ticks_frame", 32'(ticks), 32'd1);

        bus.bright = 3'd0; wei_hi = 0;
        run(64);
        chk("lit_cycles_b0", 32'(wei_hi), 32'd4);
        bus.bright = 3'd3; wei_hi = 0;
        run(64);
        chk("lit_cycles_b3", 32'(wei_hi), 32'd16);

        bus.bright = 3'd7;
        bus.digits = 32'h0234_5678;
        bus.lzb    = 4'b1000;
        run(64);
        bus.lzb    = 4'b0000;
        run(64);
        bus.dp_mask = 8'h80;
        bus.lzb     = 4'b1000;
        run(64);

        bus.dp_mask    = 8'h00;
        bus.lzb        = 4'b0000;
        bus.digits     = 32'h1234_5678;
        bus.blink_mask = 8'h01;
        do_reset();
        ticks = 0;
        run(6 * 64);
        chk("ticks_blink_run", 32'(ticks), 32'd6);
        bus.blink_mask = 8'h00;

        do_reset();
        for (int i = 0; i < 200 && m_cyc != 2 * SD + 9; i++) step();
        chk("reached_pos2_slot9", 32'(m_cyc), 32'(2 * SD + 9));
        rst = 1'b1;
        step();
        rst = 1'b0;
        wei_hi = 0;
        run(DT + 1);
        chk("lit_before_dead", 32'(wei_hi), 32'd1);
        run(64);

        bus.digits = 32'hDADA_DADA;
        run(64);

        bus.digits = 32'h1234_5678;
        bus.en = 1'b0; wei_hi = 0; ticks = 0;
        run(128);
        chk("dark_when_disabled", 32'(wei_hi), 32'd0);
        chk("ticks_when_disabled", 32'(ticks), 32'd2);
        bus.en = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 6))
                    0: bus.digits     = $urandom;
                    1: bus.dp_mask    = 8'($urandom);
                    2: bus.blink_mask = 8'($urandom);
                    3: bus.lzb        = 4'($urandom);
                    4: bus.bright     = 3'($urandom);
                    5: bus.en         = ($urandom_range(0, 3) != 0);
                    default: bus.digits = {$urandom_range(0, 1) ? 4'd0 : 4'($urandom), 28'($urandom)};
                endcase
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
